// File: rtl/sram.sv
// rtl/sram.sv - single-port 256x8 synchronous RAM with power-on clear sequencer
//
// Purpose:
//   Scratch storage on the system bus. After reset an init sequencer writes
//   zero to every word, one word per clock, before any access is accepted.
//   Reads are registered (one-cycle latency).
//
// Ports:
//   clk    in   1    system clock, rising edge
//   rst    in   1    synchronous active-high reset
//   cs     in   1    chip select, ignored while ready=0
//   wr     in   1    write strobe, qualified by cs
//   rd     in   1    read strobe, qualified by cs
//   addr   in   AW   word address
//   din    in   DW   write data
//   dout   out  DW   registered read data
//   ready  out  1    high once the clear sequence has finished
//
// Configuration macro:
//   SRAM_BYPASS_EN - when defined, a simultaneous read and write returns the
//                    new data (write-through); otherwise the old contents.

module sram #(
   parameter int DW = 8,
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cs,
   input  logic          wr,
   input  logic          rd,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic          ready
);

   localparam int DEPTH = 2**AW;

   typedef enum logic {INIT, RUN} state_t;

   state_t        state;
   logic [AW-1:0] cnt;
   logic [DW-1:0] mem [DEPTH];

   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;

   // One write port shared by the clear sequencer and bus writes.
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = addr;
      mem_wdata = din;
      if (!rst) begin
         if (state == INIT) begin
            mem_we    = 1'b1;
            mem_addr  = cnt;
            mem_wdata = '0;
         end else if (cs && wr) begin
            mem_we = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we)
         mem[mem_addr] <= mem_wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dout  <= '0;
         ready <= 1'b0;
         state <= INIT;
         cnt   <= '0;
      end else begin
         case (state)
            INIT: begin
               cnt <= cnt + AW'(1);
               // The edge that clears the last word also opens the bus.
               if (cnt == '1) begin
                  ready <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               if (cs && rd) begin
`ifdef SRAM_BYPASS_EN
                  dout <= wr ? din : mem[addr];
`else
                  // Non-blocking write means mem[addr] still holds old data here.
                  dout <= mem[addr];
`endif
               end
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_sram.sv
// tb/tb_sram.sv - self-checking scoreboard bench for sram

module tb_sram;

   logic       clk;
   logic       rst;
   logic       cs;
   logic       wr;
   logic       rd;
   logic [7:0] addr;
   logic [7:0] din;
   logic [7:0] dout;
   logic       ready;

   int n_tests;
   int n_fail;

   logic [7:0] model_mem [256];
   logic [7:0] model_dout;
   logic       model_ready;
   logic [7:0] exp_q [$];

   sram dut (
      .clk   (clk),
      .rst   (rst),
      .cs    (cs),
      .wr    (wr),
      .rd    (rd),
      .addr  (addr),
      .din   (din),
      .dout  (dout),
      .ready (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One bus cycle: drive at negedge, predict, compare dout just after the posedge.
   task automatic op(input string tag, input logic c, input logic w, input logic r,
                     input logic [7:0] a, input logic [7:0] d);
      logic [7:0] e;
      @(negedge clk);
      cs = c; wr = w; rd = r; addr = a; din = d;
      if (model_ready && c) begin
         if (r) begin
`ifdef SRAM_BYPASS_EN
            model_dout = w ? d : model_mem[a];
`else
            model_dout = model_mem[a];
`endif
         end
         if (w) model_mem[a] = d;
      end
      exp_q.push_back(model_dout);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check(tag, {24'd0, dout}, {24'd0, e});
   endtask

   task automatic idle_bus();
      cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = 8'h00; din = 8'h00;
   endtask

   task automatic apply_reset(input int cycles);
      @(negedge clk);
      idle_bus();
      rst = 1'b1;
      repeat (cycles) @(posedge clk);
      #1;
      check("reset_dout", {24'd0, dout}, 32'h0);
      check("reset_ready", {31'd0, ready}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      model_ready = 1'b0;
      model_dout  = 8'h00;
      for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
   endtask

   task automatic wait_ready(input int budget);
      int k;
      k = 0;
      while (!ready && k < budget) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("ready_timeout", {31'd0, ready}, 32'h1);
      model_ready = 1'b1;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      model_ready = 1'b0;
      model_dout  = 8'h00;
      rst = 1'b1;
      idle_bus();

      // 1: ready rises exactly 256 edges after reset release
      apply_reset(2);
      for (int i = 1; i <= 256; i++) begin
         @(posedge clk);
         #1;
         if (i == 1)   check("init_dout", {24'd0, dout}, 32'h0);
         if (i == 255) check("ready_edge255", {31'd0, ready}, 32'h0);
         if (i == 256) check("ready_edge256", {31'd0, ready}, 32'h1);
      end
      model_ready = 1'b1;
      op("rd_55_cleared", 1, 0, 1, 8'h55, 8'h00);

      // 2: write then read, dout holds when rd drops
      op("wr_10", 1, 1, 0, 8'h10, 8'hA5);
      op("rd_10", 1, 0, 1, 8'h10, 8'h00);
      op("hold_10", 1, 0, 0, 8'h10, 8'h00);

      // 3: deselected write ignored, dout unchanged meanwhile
      op("cs0_wr_20", 0, 1, 1, 8'h20, 8'h3C);
      op("rd_20", 1, 0, 1, 8'h20, 8'h00);

      // 4: simultaneous read and write
      op("wr_30", 1, 1, 0, 8'h30, 8'h11);
      op("rdwr_30", 1, 1, 1, 8'h30, 8'h22);
      op("rd_30_after", 1, 0, 1, 8'h30, 8'h00);

      // 6: address/data boundaries
      op("wr_ff", 1, 1, 0, 8'hFF, 8'hFF);
      op("wr_00", 1, 1, 0, 8'h00, 8'h01);
      op("rd_ff", 1, 0, 1, 8'hFF, 8'h00);
      op("rd_00", 1, 0, 1, 8'h00, 8'h00);

      // random traffic against the model
      for (int i = 0; i < 40; i++)
         op("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

      // 5: reset clears memory; writes during init ignored
      op("wr_05", 1, 1, 0, 8'h05, 8'h77);
      op("rd_05", 1, 0, 1, 8'h05, 8'h00);
      apply_reset(1);
      op("init_wr_06", 1, 1, 0, 8'h06, 8'h99);
      op("init_rd_06", 1, 0, 1, 8'h06, 8'h00);
      @(negedge clk);
      idle_bus();
      wait_ready(300);
      op("rd_05_cleared", 1, 0, 1, 8'h05, 8'h00);
      op("rd_06_cleared", 1, 0, 1, 8'h06, 8'h00);
      op("rd_10_cleared", 1, 0, 1, 8'h10, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
